smpl_cnt_mon: RTL
=================

Name: smpl_cnt_mon

Overview:
- Parametrised multi-lane successor of the per-triangle sample hit counter in the verif scoreboard path.
- Tracks the triangle stream delayed by PIPE_DEPTH so it lines up with LANES parallel sample-hit lanes, and counts hits per triangle.
- On each triangle boundary or flush, emits one record {sequence number, hit count, vertices} through a valid/ready FIFO for a DPI checker or logger.
- Adds per-lane enables, saturation, drop accounting and sticky error flags.

Parameters:
SIGFIG, 24, bits per coordinate
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex
LANES, 3, parallel sample-hit lanes (1..8)
PIPE_DEPTH, 3, cycles between triangle input and aligned hit lanes (>=1)
CNT_W, 32, hit-count width
SEQ_W, 16, triangle sequence-number width
FIFO_DEPTH, 4, record FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
tri_R16S  in  VERTS x AXIS x SIGFIG  triangle vertices, signed
validSamp_R16H  in  1  triangle/sample stream valid
hit_valid_R18H  in  LANES  per-lane hit valid, aligned PIPE_DEPTH after R16
lane_en  in  LANES  static lane mask; masked lanes never count
flush  in  1  close the open triangle, emit its record
rec_valid  out  1  record available
rec_ready  in  1  consumer accepts record
rec_seq  out  SEQ_W  triangle sequence number
rec_count  out  CNT_W  hits for that triangle
rec_tri  out  VERTS x AXIS x SIGFIG  triangle vertices
drop_cnt  out  16  records lost to a full FIFO (saturating)
err_stray  out  1  sticky: enabled hit while state IDLE
err_sat  out  1  sticky: a count saturated

Behaviour:
- All state, including the FIFO, clears on a clk edge with rst=0. Reset values: rec_valid=0, rec_seq=0, rec_count=0, rec_tri=0, drop_cnt=0, err_stray=0, err_sat=0, state=IDLE, seq=0.
- Reset mid-operation discards the open count and all FIFO contents. No record is emitted.
- tri_R16S and validSamp_R16H are delayed by PIPE_DEPTH to give tri_A and val_A. tri_P holds the tri_A of the previous cycle.
- newtri = val_A & (state==IDLE | tri_A != tri_P).
- lane_hits = popcount(hit_valid_R18H & lane_en), range 0..LANES.
- State machine, two states: IDLE and OPEN.
  - IDLE: on newtri, capture tri_A, set cnt = lane_hits, go to OPEN. Any lane_hits>0 without newtri sets err_stray and is discarded.
  - OPEN with newtri: push {seq, cnt, open tri}, seq += 1 (wraps at 2^SEQ_W), start the new triangle with cnt = lane_hits (current-cycle hits belong to the new triangle).
  - OPEN without newtri: cnt += lane_hits.
  - OPEN with flush and no newtri: push the record including this cycle's hits, seq += 1, go to IDLE.
  - OPEN with flush and newtri in the same cycle: push the old record. The new triangle is opened and stays OPEN; flush does not close it.
  - flush in IDLE: no effect.
- Saturation: cnt stops at 2^CNT_W-1 and sets err_sat.
- FIFO:
  - First-word-fall-through. rec_* are driven from the head entry. rec_valid = not empty.
  - Pop on rec_valid & rec_ready.
  - Push when full succeeds only if a pop happens the same cycle. Otherwise the record is dropped and drop_cnt increments, saturating at 0xFFFF.
  - Push to empty: rec_valid rises on the next cycle, so push-to-output latency is 1.
- Record latency: triangle input at R16 to its record at rec_* is at least PIPE_DEPTH + 2 cycles after its last hit cycle.

Optional Feature:
- Macro SMPL_CNT_ZERO_SKIP_EN.
- Defined: a record with cnt==0 is not pushed. seq still increments, so gaps in rec_seq mark empty triangles. drop_cnt is unaffected.
- Undefined: every closed triangle pushes a record, including cnt==0.

Test Plan:
- Single triangle T0 valid 5 cycles; lanes 3'b111, 3'b101, 0, 3'b001, 3'b011 with lane_en=3'b111; then flush -> one record: seq=0, count=8, rec_tri=T0.
- Back-to-back T0 (2 cycles, hits 3'b001 each) then T1 (1 cycle, hits 3'b110), then flush -> records (0,2,T0) and (1,2,T1). The hits on T1's first cycle are counted to T1.
- lane_en=3'b010 with all lanes hitting for 4 cycles on T0, then flush -> count=4.
- rec_ready=0 while 6 triangles close, FIFO_DEPTH=4 -> 4 records held, drop_cnt=2. Then rec_ready=1 -> seq 0..3 delivered in order.
- Hit 3'b001 with no valid triangle after reset -> err_stray=1 and no record. Then assert rst=0 for one edge -> err_stray=0, rec_valid=0.
- Empty triangle: T0 valid 3 cycles with no hits, then flush -> macro undefined: record (0,0,T0). Macro defined: no record, and the next triangle reports seq=1.

Source files
------------

// File: rtl/smpl_cnt_mon.sv
// smpl_cnt_mon: per-triangle sample-hit counter; build with SMPL_CNT_ZERO_SKIP_EN to drop zero-count records.
// Latency: a record reaches rec_* one cycle after its triangle closes (>= PIPE_DEPTH+2 after its last R16 cycle).
// Backpressure: rec_valid/rec_ready FIFO; a record closed while the FIFO is full and not popping is dropped and counted.

module smpl_cnt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push_vld,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop_rdy,
    output logic         o_empty,
    output logic         o_drop,
    output logic [W-1:0] o_head_dat
);
    // Generic first-word-fall-through FIFO with synchronous active-low reset.
    // Latency: push to head visible one cycle later.
    // Backpressure: a push while full succeeds only alongside a pop, otherwise o_drop pulses.

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_full;
    logic         w_pop;
    logic         w_wr;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = i_pop_rdy & ~o_empty;
    // When full, the write slot is the head slot being popped, so overwriting it is safe.
    assign w_wr       = i_push_vld & (~w_full | w_pop);
    assign o_drop     = i_push_vld & ~w_wr;
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end
endmodule

module smpl_cnt_mon #(
    parameter int SIGFIG     = 24,
    parameter int VERTS      = 3,
    parameter int AXIS       = 3,
    parameter int LANES      = 3,
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 32,
    parameter int SEQ_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
    input  logic                                   validSamp_R16H,
    input  logic [LANES-1:0]                       hit_valid_R18H,
    input  logic [LANES-1:0]                       lane_en,
    input  logic                                   flush,
    output logic                                   rec_valid,
    input  logic                                   rec_ready,
    output logic [SEQ_W-1:0]                       rec_seq,
    output logic [CNT_W-1:0]                       rec_count,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] rec_tri,
    output logic [15:0]                            drop_cnt,
    output logic                                   err_stray,
    output logic                                   err_sat
);
    // Aligns triangles to the hit lanes, counts enabled hits per triangle, emits {seq,count,vertices}.
    // Latency: record visible one cycle after the closing cycle (newtri or flush at the aligned stage).
    // Backpressure: rec_ready pops the FIFO; closes while full without a pop bump drop_cnt.

    localparam int HW = $clog2(LANES + 1);

    typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] vtx_t;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [CNT_W-1:0] cnt;
        vtx_t             vtx;
    } rec_t;

    typedef enum logic {
        IDLE,
        OPEN
    } state_t;

    vtx_t             r_tri_pipe [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] r_val_pipe;
    vtx_t             r_tri_p;
    vtx_t             r_tri_open;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SEQ_W-1:0] r_seq;
    logic [15:0]      r_drop_cnt;
    logic             r_err_stray;
    logic             r_err_sat;

    vtx_t             w_tri_a;
    logic             w_val_a;
    logic             w_newtri;
    logic [LANES-1:0] w_masked;
    logic [HW-1:0]    w_hits;
    logic [CNT_W:0]   w_sum;
    logic             w_acc_sat;
    logic [CNT_W-1:0] w_cnt_acc;
    logic             w_close;
    logic             w_push;
    rec_t             w_rec;
    rec_t             w_head;
    logic             w_empty;
    logic             w_drop;

    assign w_tri_a  = r_tri_pipe[PIPE_DEPTH-1];
    assign w_val_a  = r_val_pipe[PIPE_DEPTH-1];
    assign w_newtri = w_val_a & ((r_state == IDLE) | (w_tri_a != r_tri_p));
    assign w_masked = hit_valid_R18H & lane_en;

    always_comb begin
        w_hits = '0;
        for (int i = 0; i < LANES; i++) begin
            w_hits = w_hits + HW'(w_masked[i]);
        end
    end

    assign w_sum     = {1'b0, r_cnt} + (CNT_W+1)'(w_hits);
    assign w_acc_sat = w_sum[CNT_W];
    assign w_cnt_acc = w_acc_sat ? '1 : w_sum[CNT_W-1:0];
    assign w_close   = (r_state == OPEN) & (w_newtri | flush);

    // A new triangle takes this cycle's hits; a bare flush folds them into the closing record.
    always_comb begin
        w_rec     = '0;
        w_rec.seq = r_seq;
        w_rec.cnt = w_newtri ? r_cnt : w_cnt_acc;
        w_rec.vtx = r_tri_open;
    end

`ifdef SMPL_CNT_ZERO_SKIP_EN
    assign w_push = w_close & (w_rec.cnt != '0);
`else
    assign w_push = w_close;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_tri_pipe[i] <= '0;
            end
            r_val_pipe  <= '0;
            r_tri_p     <= '0;
            r_tri_open  <= '0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_seq       <= '0;
            r_drop_cnt  <= '0;
            r_err_stray <= 1'b0;
            r_err_sat   <= 1'b0;
        end else begin
            r_tri_pipe[0] <= tri_R16S;
            r_val_pipe[0] <= validSamp_R16H;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_tri_pipe[i] <= r_tri_pipe[i-1];
                r_val_pipe[i] <= r_val_pipe[i-1];
            end
            r_tri_p <= w_tri_a;

            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    if (w_newtri) begin
                        r_tri_open <= w_tri_a;
                        r_cnt      <= CNT_W'(w_hits);
                        r_state    <= OPEN;
                    end else if (w_hits != '0) begin
                        r_err_stray <= 1'b1;
                    end
                end
                OPEN: begin
                    if (w_newtri) begin
                        r_seq      <= r_seq + SEQ_W'(1);
                        r_tri_open <= w_tri_a;
                        r_cnt      <= CNT_W'(w_hits);
                    end else begin
                        if (w_acc_sat) begin
                            r_err_sat <= 1'b1;
                        end
                        if (flush) begin
                            r_seq   <= r_seq + SEQ_W'(1);
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= w_cnt_acc;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    smpl_cnt_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rec_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (w_push),
        .i_push_dat (w_rec),
        .i_pop_rdy  (rec_ready),
        .o_empty    (w_empty),
        .o_drop     (w_drop),
        .o_head_dat (w_head)
    );

    assign rec_valid = ~w_empty;
    assign rec_seq   = w_head.seq;
    assign rec_count = w_head.cnt;
    assign rec_tri   = w_head.vtx;
    assign drop_cnt  = r_drop_cnt;
    assign err_stray = r_err_stray;
    assign err_sat   = r_err_sat;
endmodule
